lcg_stim_gen: RTL and testbench

- Upstream stimulus source for the fuzzed `top` DUT harness.
- Generates the DUT's flat input vector (`in_flat`) from a 32-bit LCG (Linear Congruential Generator). Words are produced one per clock.
- Each completed vector is presented over a valid/ready handshake.
- Makes stimulus generation synthesizable and reproducible per seed. Vectors are bit-identical to the harness's software LCG sequence for the same seed.

---
 rtl/lcg_stim_gen.sv | 147 ++++++++++++++
 tb/tb_lcg_stim_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcg_stim_gen.sv
// LCG-driven stimulus source: assembles OUT_W-bit vectors one 32-bit word
// per clock and presents each one over a valid/ready handshake.
module lcg_stim_gen #(
  parameter int          OUT_W   = 266,
  parameter logic [31:0] LCG_MUL = 32'h41C64E6D,
  parameter logic [31:0] LCG_INC = 32'h00003039
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [31:0]      num_vectors,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [OUT_W-1:0] vec_data,
  output logic [31:0]      vec_count,
  output logic             busy,
  output logic             done
);

  localparam int NWORDS = (OUT_W + 31) / 32;
  localparam int LASTW  = OUT_W - 32 * (NWORDS - 1);
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_PRES = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      lcg_q, lcg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [OUT_W-1:0] shadow_q, shadow_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      num_q, num_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [31:0]      lcg_nxt;
  logic [OUT_W-1:0] ins;

  assign lcg_nxt = lcg_q * LCG_MUL + LCG_INC;

  // Shadow vector with the current word dropped into slot idx_q;
  // the top slot keeps only the bits that fit in OUT_W.
  always_comb begin
    ins = shadow_q;
    for (int k = 0; k < NWORDS - 1; k++) begin
      if (idx_q == IW'(k)) begin
        ins[32*k +: 32] = lcg_nxt;
      end
    end
    if (idx_q == LAST_IDX) begin
      ins[OUT_W-1 -: LASTW] = lcg_nxt[LASTW-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    lcg_d    = lcg_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (num_vectors != '0) begin
            lcg_d   = seed;
            num_d   = num_vectors;
            idx_d   = '0;
            state_d = S_GEN;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_GEN: begin
        lcg_d    = lcg_nxt;
        shadow_d = ins;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          valid_d = 1'b1;
          data_d  = ins;
          state_d = S_PRES;
        end
      end
      S_PRES: begin
        if (valid_q && vec_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 32'd1;
          if (cnt_q + 32'd1 == num_q) begin
            state_d = S_FIN;
          end else begin
            idx_d   = '0;
            state_d = S_GEN;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lcg_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      num_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lcg_q    <= lcg_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign vec_valid = valid_q;
  assign vec_data  = data_q;
  assign vec_count = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Bench for lcg_stim_gen: software LCG vector model with a per-cycle
// monitor, plus directed latency, stall, restart and reset scenarios.
module tb_lcg_stim_gen;

  localparam int          OUT_W = 266;
  localparam int          NW    = (OUT_W + 31) / 32;
  localparam logic [31:0] MUL   = 32'h41C64E6D;
  localparam logic [31:0] INC   = 32'h00003039;

  logic             clk = 1'b0;
  logic             rst, start, vec_ready;
  logic [31:0]      seed, num_vectors;
  logic             vec_valid, busy, done;
  logic [OUT_W-1:0] vec_data;
  logic [31:0]      vec_count;

  always #5 clk = ~clk;

  lcg_stim_gen #(.OUT_W(OUT_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .seed(seed),
    .num_vectors(num_vectors),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .vec_data(vec_data),
    .vec_count(vec_count),
    .busy(busy),
    .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          run_id   = 0;
  logic [31:0] run_seed = '0;

  int               m_acc       = 0;
  int               done_pulses = 0;
  logic             m_active    = 1'b0;
  logic [31:0]      m_lcg;
  logic [OUT_W-1:0] m_exp;

  // Software LCG: NW successive words, word k in bits [32k+31:32k].
  task automatic next_vec(input logic [31:0] si,
                          output logic [31:0] so,
                          output logic [OUT_W-1:0] v);
    logic [32*NW-1:0] w;
    logic [31:0]      s;
    s = si;
    w = '0;
    for (int k = 0; k < NW; k++) begin
      s = s * MUL + INC;
      w[32*k +: 32] = s;
    end
    so = s;
    v  = w[OUT_W-1:0];
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin : mon
    int seen_id;
    seen_id = 0;
    forever begin
      @(negedge clk);
      if (done) done_pulses++;
      if (rst) begin
        m_active = 1'b0;
      end else if (run_id != seen_id) begin
        seen_id = run_id;
        next_vec(run_seed, m_lcg, m_exp);
        m_acc    = 0;
        m_active = 1'b1;
      end else if (m_active) begin
        chk("vec_count", vec_count, 64'(m_acc));
        if (vec_valid) begin
          n_tests++;
          if (vec_data !== m_exp) begin
            n_fail++;
            $display("FAIL vec_data#%0d: got %h expected %h",
                     m_acc, vec_data, m_exp);
          end
          if (vec_ready) begin
            m_acc++;
            next_vec(m_lcg, m_lcg, m_exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] s, input logic [31:0] n);
    seed        = s;
    num_vectors = n;
    run_seed    = s;
    run_id++;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int bound,
                           input bit rnd_ready, input bit rnd_start);
    int c;
    c = 0;
    while (!done && c < bound) begin
      if (rnd_ready) vec_ready = 1'($urandom_range(0, 1));
      if (rnd_start) begin
        start       = busy && ($urandom_range(0, 2) == 0);
        seed        = $urandom;
        num_vectors = $urandom;
      end
      tick();
      c++;
    end
    start = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", nm, bound);
    end
  endtask

  initial begin : drv
    logic [31:0]      s_tmp, s5;
    logic [OUT_W-1:0] v_tmp, sv;
    logic [63:0]      lo;
    int               lat, dp, c;

    rst = 1'b1; start = 1'b0; vec_ready = 1'b0;
    seed = '0; num_vectors = '0;
    repeat (3) tick();
    lo = vec_data[63:0];
    chk("rst_valid", {63'd0, vec_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_count", {32'd0, vec_count}, 64'd0);
    chk("rst_data", lo, 64'd0);
    rst = 1'b0;
    tick();

    next_vec(32'd0, s_tmp, v_tmp);
    chk("model_w0", {32'd0, v_tmp[31:0]}, 64'h3039);
    chk("model_w1", {32'd0, v_tmp[63:32]}, 64'hD3DC167E);

    // First vector latency and literal words.
    vec_ready = 1'b1;
    dp = done_pulses;
    start_run(32'd0, 32'd1);
    lat = 0;
    while (!vec_valid && lat < 50) begin tick(); lat++; end
    chk("latency", 64'(lat), 64'd9);
    chk("t1_w0", {32'd0, vec_data[31:0]}, 64'h3039);
    chk("t1_w1", {32'd0, vec_data[63:32]}, 64'hD3DC167E);
    lat = 0;
    while (!done && lat < 50) begin tick(); lat++; end
    chk("done_delay", 64'(lat), 64'd2);
    chk("t1_count", {32'd0, vec_count}, 64'd1);
    chk("t1_busy", {63'd0, busy}, 64'd0);
    repeat (3) tick();
    chk("t1_pulses", 64'(done_pulses - dp), 64'd1);

    // 100-vector run, always ready.
    dp = done_pulses;
    start_run(32'd1196342297, 32'd100);
    wait_done("t2_done", 1500, 1'b0, 1'b0);
    repeat (3) tick();
    chk("t2_count", {32'd0, vec_count}, 64'd100);
    chk("t2_model", 64'(m_acc), 64'd100);
    chk("t2_pulses", 64'(done_pulses - dp), 64'd1);

    // Stall for 20 cycles on the first vector.
    vec_ready = 1'b0;
    start_run($urandom, 32'd3);
    c = 0;
    while (!vec_valid && c < 50) begin tick(); c++; end
    chk("t3_valid", {63'd0, vec_valid}, 64'd1);
    sv = vec_data;
    repeat (20) begin
      tick();
      chk("t3_hold_valid", {63'd0, vec_valid}, 64'd1);
      n_tests++;
      if (vec_data !== sv) begin
        n_fail++;
        $display("FAIL t3_hold_data: got %h expected %h", vec_data, sv);
      end
    end
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    chk("t3_dropped", {63'd0, vec_valid}, 64'd0);
    chk("t3_once", {32'd0, vec_count}, 64'd1);
    tick();
    vec_ready = 1'b1;
    wait_done("t3_done", 200, 1'b0, 1'b0);
    chk("t3_count", {32'd0, vec_count}, 64'd3);

    // Empty run.
    tick();
    start_run($urandom, 32'd0);
    chk("t4_busy", {63'd0, busy}, 64'd1);
    chk("t4_nodone", {63'd0, done}, 64'd0);
    tick();
    chk("t4_done", {63'd0, done}, 64'd1);
    chk("t4_busy_low", {63'd0, busy}, 64'd0);
    chk("t4_count", {32'd0, vec_count}, 64'd0);
    tick();
    chk("t4_done_low", {63'd0, done}, 64'd0);
    chk("t4_model", 64'(m_acc), 64'd0);

    // Stray start/seed/num changes while busy, random ready.
    dp = done_pulses;
    start_run($urandom, 32'd4);
    wait_done("t5_done", 600, 1'b1, 1'b1);
    vec_ready = 1'b1;
    seed = '0;
    num_vectors = '0;
    repeat (3) tick();
    chk("t5_count", {32'd0, vec_count}, 64'd4);
    chk("t5_model", 64'(m_acc), 64'd4);
    chk("t5_pulses", 64'(done_pulses - dp), 64'd1);

    // Random ready, fresh seed.
    start_run($urandom, 32'd6);
    wait_done("t6_done", 800, 1'b1, 1'b0);
    vec_ready = 1'b1;
    tick();
    chk("t6_count", {32'd0, vec_count}, 64'd6);

    // Reset in GEN of vector 3 of 5, then reproduce vector 0.
    s5 = $urandom;
    start_run(s5, 32'd5);
    c = 0;
    while (m_acc < 3 && c < 200) begin tick(); c++; end
    chk("t7_reach3", 64'(m_acc), 64'd3);
    repeat (3) tick();
    dp = done_pulses;
    rst = 1'b1;
    tick();
    lo = vec_data[63:0];
    chk("t7_valid", {63'd0, vec_valid}, 64'd0);
    chk("t7_busy", {63'd0, busy}, 64'd0);
    chk("t7_done", {63'd0, done}, 64'd0);
    chk("t7_count", {32'd0, vec_count}, 64'd0);
    chk("t7_data", lo, 64'd0);
    rst = 1'b0;
    repeat (15) tick();
    chk("t7_nopulse", 64'(done_pulses - dp), 64'd0);
    chk("t7_idle", {63'd0, busy}, 64'd0);
    start_run(s5, 32'd1);
    wait_done("t7_redo", 100, 1'b0, 1'b0);
    tick();
    chk("t7_redo_count", {32'd0, vec_count}, 64'd1);
    chk("t7_redo_model", 64'(m_acc), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
